// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: turns per-stage stall, flush and multi-cycle hold
// requests into stall/flush strobes, tracks per-stage valid bits and counts stall/flush cycles.
module pipe_hazard_ctl #(
   parameter int NUM_STAGES = 5,
   parameter int CNT_W      = 32,
   parameter int HOLD_W     = 4,
   localparam int SEL_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  global_stall,
   input  logic [NUM_STAGES-1:0] stall_req,
   input  logic [NUM_STAGES-1:0] flush_req,
   input  logic                  hold_req,
   input  logic [HOLD_W-1:0]     hold_cycles,
   input  logic [SEL_W-1:0]      hold_stage,
   input  logic                  valid_in,
   input  logic                  clr_cnt,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_STAGES-1:0] flush,
   output logic [NUM_STAGES-1:0] valid,
   output logic                  hold_busy,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   logic [HOLD_W-1:0]     holdCnt;
   logic [SEL_W-1:0]      holdStageQ;
   logic                  holdBusy;
   logic [NUM_STAGES-1:0] rawReq;
   logic [NUM_STAGES-1:0] unmasked;
   logic [NUM_STAGES-1:0] honoured;
   logic [NUM_STAGES-1:0] squash;
   logic [NUM_STAGES-1:0] bubble;
   logic [NUM_STAGES-1:0] stallInt;
   logic [NUM_STAGES-1:0] flushInt;
   logic [NUM_STAGES-1:0] nextValid;
   logic                  anyFlush;

   assign holdBusy  = (holdCnt != '0);
   assign hold_busy = holdBusy;

   always_comb begin
      rawReq = '0;
      for (int j = 0; j < NUM_STAGES; j++) begin
         rawReq[j] = stall_req[j] | (holdBusy & (holdStageQ == SEL_W'(j)));
      end
   end

   // A stall in any older stage backs up every younger stage behind it.
   always_comb begin
      logic acc;
      unmasked = '0;
      acc      = global_stall;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         acc         = acc | rawReq[i];
         unmasked[i] = acc;
      end
   end

   assign honoured = flush_req & ~unmasked;
   assign anyFlush = |honoured;

   always_comb begin
      logic acc;
      squash = '0;
      acc    = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         squash[i] = acc;
         acc       = acc | honoured[i];
      end
   end

   assign stallInt = unmasked & ~squash;

   // A moving stage directly downstream of a held stage must take in a bubble.
   always_comb begin
      bubble = '0;
      for (int i = 1; i < NUM_STAGES; i++) begin
         bubble[i] = stallInt[i-1] & ~unmasked[i];
      end
   end

   assign flushInt = squash | bubble;
   assign stall    = reset ? '0 : stallInt;
   assign flush    = reset ? '1 : flushInt;

   always_comb begin
      nextValid = '0;
      if (flushInt[0])
         nextValid[0] = 1'b0;
      else if (stallInt[0])
         nextValid[0] = valid[0];
      else
         nextValid[0] = valid_in;
      for (int i = 1; i < NUM_STAGES; i++) begin
         if (flushInt[i])
            nextValid[i] = 1'b0;
         else if (stallInt[i])
            nextValid[i] = valid[i];
         else
            nextValid[i] = valid[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         valid <= '0;
      else
         valid <= nextValid;
   end

   // Requests arriving while a hold is running, or with a zero length, are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         holdCnt    <= '0;
         holdStageQ <= '0;
      end else if (holdBusy) begin
         holdCnt <= holdCnt - HOLD_W'(1);
      end else if (hold_req && (hold_cycles != '0)) begin
         holdCnt    <= hold_cycles;
         holdStageQ <= hold_stage;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (clr_cnt) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stallInt[0] && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (anyFlush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: directed scenarios then random traffic, all
// checked against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctl;

   localparam int N    = 5;
   localparam int CW   = 4;
   localparam int HW   = 4;
   localparam int SW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          global_stall = 1'b0;
   logic [N-1:0]  stall_req = '0;
   logic [N-1:0]  flush_req = '0;
   logic          hold_req = 1'b0;
   logic [HW-1:0] hold_cycles = '0;
   logic [SW-1:0] hold_stage = '0;
   logic          valid_in = 1'b0;
   logic          clr_cnt = 1'b0;
   logic [N-1:0]  stall;
   logic [N-1:0]  flush;
   logic [N-1:0]  valid;
   logic          hold_busy;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   pipe_hazard_ctl #(.NUM_STAGES(N), .CNT_W(CW), .HOLD_W(HW)) dut (
      .clk(clk), .reset(reset), .global_stall(global_stall),
      .stall_req(stall_req), .flush_req(flush_req), .hold_req(hold_req),
      .hold_cycles(hold_cycles), .hold_stage(hold_stage), .valid_in(valid_in),
      .clr_cnt(clr_cnt), .stall(stall), .flush(flush), .valid(valid),
      .hold_busy(hold_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] stall;
      logic [N-1:0] flush;
      logic [N-1:0] valid;
      logic         busy;
      int           scnt;
      int           fcnt;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   int mValid[N];
   int mHoldRem = 0;
   int mHoldStage = 0;
   int mStallCnt = 0;
   int mFlushCnt = 0;

   // Reference model: expected outputs of the current cycle, then state after the edge.
   task automatic modelStep();
      exp_t e;
      int   u[N];
      int   hon[N];
      int   sOut[N];
      int   fOut[N];
      int   nv[N];
      int   anyHon;
      if (reset) begin
         for (int i = 0; i < N; i++) mValid[i] = 0;
         mHoldRem = 0; mStallCnt = 0; mFlushCnt = 0;
         e.stall = '0; e.flush = '1; e.valid = '0; e.busy = 1'b0; e.scnt = 0; e.fcnt = 0;
         expQ.push_back(e);
         return;
      end
      for (int i = 0; i < N; i++) begin
         u[i] = global_stall;
         for (int j = i; j < N; j++)
            if (stall_req[j] || (mHoldRem > 0 && mHoldStage == j)) u[i] = 1;
      end
      anyHon = 0;
      for (int j = 0; j < N; j++) begin
         hon[j] = (flush_req[j] && u[j] == 0) ? 1 : 0;
         if (hon[j] != 0) anyHon = 1;
      end
      for (int i = 0; i < N; i++) begin
         fOut[i] = 0;
         for (int j = i + 1; j < N; j++) if (hon[j] != 0) fOut[i] = 1;
         sOut[i] = (u[i] != 0 && fOut[i] == 0) ? 1 : 0;
      end
      for (int i = 1; i < N; i++)
         if (sOut[i-1] != 0 && u[i] == 0) fOut[i] = 1;
      for (int i = 0; i < N; i++) begin
         e.stall[i] = (sOut[i] != 0);
         e.flush[i] = (fOut[i] != 0);
         e.valid[i] = (mValid[i] != 0);
      end
      e.busy = (mHoldRem > 0);
      e.scnt = mStallCnt;
      e.fcnt = mFlushCnt;
      expQ.push_back(e);
      for (int i = 0; i < N; i++) begin
         if (fOut[i] != 0)      nv[i] = 0;
         else if (sOut[i] != 0) nv[i] = mValid[i];
         else                   nv[i] = (i == 0) ? int'(valid_in) : mValid[i-1];
      end
      for (int i = 0; i < N; i++) mValid[i] = nv[i];
      if (mHoldRem > 0) mHoldRem--;
      else if (hold_req && hold_cycles != 0) begin
         mHoldRem   = int'(hold_cycles);
         mHoldStage = int'(hold_stage);
      end
      if (clr_cnt) begin
         mStallCnt = 0; mFlushCnt = 0;
      end else begin
         if (sOut[0] != 0 && mStallCnt < CMAX) mStallCnt++;
         if (anyHon != 0 && mFlushCnt < CMAX) mFlushCnt++;
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic gs, input logic [N-1:0] sreq,
                                input logic [N-1:0] freq, input logic hreq,
                                input logic [HW-1:0] hcyc, input logic [SW-1:0] hstg,
                                input logic vin, input logic clr);
      @(negedge clk);
      reset = rst; global_stall = gs; stall_req = sreq; flush_req = freq;
      hold_req = hreq; hold_cycles = hcyc; hold_stage = hstg; valid_in = vin; clr_cnt = clr;
      modelStep();
   endtask

   task automatic idle(input logic vin);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, vin, 1'b0);
   endtask

   task automatic checkOutput(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output set, compared against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("stall", int'(stall), int'(e.stall));
            checkOutput("flush", int'(flush), int'(e.flush));
            checkOutput("valid", int'(valid), int'(e.valid));
            checkOutput("hold_busy", int'(hold_busy), int'(e.busy));
            checkOutput("stall_cnt", int'(stall_cnt), e.scnt);
            checkOutput("flush_cnt", int'(flush_cnt), e.fcnt);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int waitCycles;
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      #2 checkOutput("reset flush", int'(flush), 5'h1F);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);

      $display("[TB] fill pipeline");
      for (int k = 0; k < 5; k++) idle(1'b1);
      idle(1'b0);
      #2 checkOutput("fill valid", int'(valid), 5'h1F);

      $display("[TB] single stall with bubble");
      applyStimulus(1'b0, 1'b0, 5'b00010, '0, 1'b0, '0, '0, 1'b1, 1'b0);
      #2 checkOutput("bubble stall", int'(stall), 5'b00011);
      checkOutput("bubble flush", int'(flush), 5'b00100);
      idle(1'b1);
      #2 checkOutput("bubble valid2", int'(valid[2]), 0);

      $display("[TB] honoured flush");
      applyStimulus(1'b0, 1'b0, '0, 5'b00100, 1'b0, '0, '0, 1'b1, 1'b0);
      #2 checkOutput("flush pattern", int'(flush), 5'b00011);
      idle(1'b1);
      #2 checkOutput("flushed valid", int'(valid[1:0]), 0);

      $display("[TB] flush blocked by older stall");
      applyStimulus(1'b0, 1'b0, 5'b01000, 5'b00100, 1'b0, '0, '0, 1'b1, 1'b0);
      #2 checkOutput("blocked stall", int'(stall), 5'b01111);
      checkOutput("blocked flush", int'(flush), 5'b10000);

      $display("[TB] multi-cycle hold");
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd3, 3'd3, 1'b1, 1'b0);
      #2 checkOutput("hold not yet busy", int'(hold_busy), 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, k == 1, 4'd5, 3'd1, 1'b1, 1'b0);
         #2 checkOutput("hold busy", int'(hold_busy), 1);
         checkOutput("hold stall", int'(stall), 5'b01111);
      end
      idle(1'b1);
      #2 checkOutput("hold done", int'(hold_busy), 0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd0, 3'd2, 1'b1, 1'b0);
      idle(1'b1);
      #2 checkOutput("zero hold ignored", int'(hold_busy), 0);

      $display("[TB] reset during hold");
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'd10, 3'd2, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
      #2 checkOutput("abort busy", int'(hold_busy), 0);
      checkOutput("abort valid", int'(valid), 0);
      checkOutput("abort counts", int'(stall_cnt) + int'(flush_cnt), 0);
      checkOutput("abort flush", int'(flush), 5'h1F);
      idle(1'b1);
      idle(1'b0);
      #2 checkOutput("post reset valid", int'(valid), 5'b00001);

      $display("[TB] random traffic");
      for (int k = 0; k < 2000; k++) begin
         logic [N-1:0] sreq;
         logic [N-1:0] freq;
         for (int b = 0; b < N; b++) begin
            sreq[b] = ($urandom_range(0, 9) == 0);
            freq[b] = ($urandom_range(0, 7) == 0);
         end
         applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0, sreq, freq,
                       $urandom_range(0, 7) == 0, HW'($urandom_range(0, 15)),
                       SW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 99) == 0);
      end
      idle(1'b0);

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      #3;
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
